imem_arbiter: RTL
=================

// Module: imem_arbiter
// PURPOSE
//  Shares the single synchronous-read instruction memory between the fetch stage (IF) and a
//  data-side load port (LD) for PC-relative constant/literal reads. One request is granted
//  per cycle; the memory returns data one cycle after address capture. The response is routed
//  to the winner, with anti-starvation aging and fetch flush. Sits between core and imem.
// PARAMETERS
//  BASE_ADDR  32'h8000_0000  byte address of memory word 0
//  DEPTH      256            memory depth in 32-bit words
//  MAX_WAIT   4              consecutive IF losses before IF gets forced priority (1..15)
// PORTS
//  clk          in   1   clock, all state on posedge
//  rst_n        in   1   asynchronous active-low reset
//  if_req_valid in   1   IF request
//  if_req_addr  in   32  IF byte address
//  if_req_ready out  1   IF request accepted this cycle
//  if_flush     in   1   discard any IF response due next cycle
//  if_rsp_valid out  1   IF response valid
//  if_rsp_data  out  32  IF response word
//  if_rsp_err   out  1   IF response error (see CONFIGURATION)
//  ld_req_valid in   1   LD request
//  ld_req_addr  in   32  LD byte address
//  ld_req_ready out  1   LD request accepted this cycle
//  ld_rsp_valid out  1   LD response valid
//  ld_rsp_data  out  32  LD response word
//  ld_rsp_err   out  1   LD response error
//  mem_addr     out  32  byte address to imem, sampled by imem on posedge
//  mem_rdata    in   32  imem read word, valid the cycle after mem_addr sampled
// BEHAVIOUR
//  - Reset: all *_ready, *_rsp_valid, *_rsp_err = 0; wait_cnt = 0; owner = NONE; mem_addr = 0.
//  - Arbitration (combinational, per cycle): default LD beats IF. If wait_cnt >= MAX_WAIT,
//    IF beats LD. Only one of if_req_ready/ld_req_ready is 1 in a cycle. ready=valid&&granted.
//  - No requester-side backpressure on responses; requests accepted back-to-back every cycle.
//  - mem_addr = granted request's address; when no request, mem_addr holds its last value.
//  - wait_cnt: +1 (saturate at 15) each cycle IF valid but not granted; cleared on IF grant
//    or when if_req_valid=0.
//  - owner register (NONE/IF/LD) written every posedge with this cycle's winner.
//  - Latency exactly 1: cycle N accept -> cycle N+1 <x>_rsp_valid=1 (registered),
//    <x>_rsp_data = mem_rdata (combinational pass-through), other rsp_data = 0.
//  - Flush: if_flush=1 in cycle N+1 forces if_rsp_valid=0 that cycle; if_flush with
//    simultaneous IF request in same cycle still accepts the new request (resp in N+2).
//  - Simultaneous IF+LD valid, wait_cnt<MAX_WAIT: LD granted, IF ready=0, wait_cnt+1.
//  - Address arithmetic: word index = (addr - BASE_ADDR) >> 2, computed modulo 2^32.
//  - Reset asserted mid-transaction: pending response dropped, no rsp_valid after release
//    until a new request is accepted.
// CONFIGURATION
//  IMEM_ARB_RANGE_CHK_EN defined: request with addr < BASE_ADDR, addr >= BASE_ADDR+DEPTH*4,
//   or addr[1:0]!=0 is still accepted (1-cycle slot consumed), but its response has
//   rsp_valid=1, rsp_err=1, rsp_data=0; mem_addr driven to BASE_ADDR for that grant.
//  Not defined: no check; *_rsp_err tied 0; out-of-range addresses pass straight to imem.
// TESTING
//  1 IF only: addr 8000_0000,8000_0004 back-to-back -> if_rsp_valid cycles 1,2, data=mem[0],mem[1].
//  2 IF+LD both valid, MAX_WAIT=4, 6 cycles -> LD granted 4 cycles, IF granted 5th, wait_cnt=0.
//  3 IF accept cycle N, if_flush=1 cycle N+1 -> if_rsp_valid=0 in N+1; no LD rsp either.
//  4 rst_n low in cycle after LD accept -> ld_rsp_valid=0, all outputs 0 until new request.
//  5 RANGE_CHK_EN: LD addr 8000_0400 (DEPTH=256) -> ld_rsp_valid=1, ld_rsp_err=1, data=0;
//    addr 8000_0002 -> err=1; without macro: err=0, data=mem[(addr-BASE)>>2 mod DEPTH].
//  6 Idle 3 cycles after IF grant -> mem_addr holds last value, no rsp_valid asserted.

Source files
------------

// File: rtl/imem_arbiter.sv
// Two-port arbiter (fetch IF, literal load LD) in front of a 1-cycle synchronous-read imem.
// Optional address range/alignment check enabled by defining IMEM_ARB_RANGE_CHK_EN.
module imem_arbiter #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          DEPTH     = 256,
  parameter int          MAX_WAIT  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req_valid,
  input  logic [31:0] if_req_addr,
  output logic        if_req_ready,
  input  logic        if_flush,
  output logic        if_rsp_valid,
  output logic [31:0] if_rsp_data,
  output logic        if_rsp_err,
  input  logic        ld_req_valid,
  input  logic [31:0] ld_req_addr,
  output logic        ld_req_ready,
  output logic        ld_rsp_valid,
  output logic [31:0] ld_rsp_data,
  output logic        ld_rsp_err,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata
);

  // Handshake: a request transfers in the cycle where valid && ready; ready is high only for
  // the single granted requester, and its response appears exactly one cycle later with no
  // backpressure on the response side.

`ifdef IMEM_ARB_RANGE_CHK_EN
  localparam bit RANGE_CHK = 1'b1;
`else
  localparam bit RANGE_CHK = 1'b0;
`endif

  localparam logic [3:0]  MAX_WAIT_L = 4'(MAX_WAIT);
  localparam logic [31:0] SPAN_BYTES = 32'(DEPTH * 4);

  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_LD} owner_t;

  owner_t      owner, owner_next;
  logic [3:0]  wait_cnt, wait_cnt_next;
  logic [31:0] addr_hold;
  logic        err_q;
  logic        if_grant, ld_grant, any_grant;
  logic [31:0] grant_addr, grant_off;
  logic        grant_bad;

  always_comb begin
    if_grant      = 1'b0;
    ld_grant      = 1'b0;
    owner_next    = OWN_NONE;
    wait_cnt_next = 4'd0;
    // LD wins by default; IF takes priority once it has lost MAX_WAIT cycles in a row.
    if (if_req_valid && (!ld_req_valid || wait_cnt >= MAX_WAIT_L)) begin
      if_grant   = 1'b1;
      owner_next = OWN_IF;
    end else if (ld_req_valid) begin
      ld_grant   = 1'b1;
      owner_next = OWN_LD;
    end
    if (if_req_valid && !if_grant) begin
      wait_cnt_next = (wait_cnt == 4'hF) ? wait_cnt : wait_cnt + 4'd1;
    end
  end

  assign any_grant    = if_grant || ld_grant;
  assign if_req_ready = if_grant;
  assign ld_req_ready = ld_grant;
  assign grant_addr   = if_grant ? if_req_addr : ld_req_addr;

  // Modulo-2^32 offset makes addresses below BASE_ADDR wrap to huge values, so one compare suffices.
  assign grant_off = grant_addr - BASE_ADDR;
  assign grant_bad = RANGE_CHK && ((grant_off >= SPAN_BYTES) || (grant_addr[1:0] != 2'b00));

  assign mem_addr = any_grant ? (grant_bad ? BASE_ADDR : grant_addr) : addr_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner     <= OWN_NONE;
      wait_cnt  <= 4'd0;
      addr_hold <= 32'd0;
      err_q     <= 1'b0;
    end else begin
      owner    <= owner_next;
      wait_cnt <= wait_cnt_next;
      err_q    <= any_grant && grant_bad;
      if (any_grant) begin
        addr_hold <= mem_addr;
      end
    end
  end

  // Read data is passed straight through to the owner; the other port and errored slots see 0.
  assign if_rsp_valid = (owner == OWN_IF) && !if_flush;
  assign if_rsp_err   = if_rsp_valid && err_q;
  assign if_rsp_data  = (if_rsp_valid && !err_q) ? mem_rdata : 32'd0;

  assign ld_rsp_valid = (owner == OWN_LD);
  assign ld_rsp_err   = ld_rsp_valid && err_q;
  assign ld_rsp_data  = (ld_rsp_valid && !err_q) ? mem_rdata : 32'd0;

endmodule
